// File: rtl/dma_chan_datapath.sv
// rtl/dma_chan_datapath.sv - multi-channel DMA address/count register file and transfer sequencer
module dma_chan_datapath #(
    parameter int NUM_CH = 4,
    parameter int AW = 16,
    parameter int CW = 16,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CS_N,
    input  logic              IOW_N,
    input  logic              IOR_N,
    input  logic [3:0]        ADDR_L,
    input  logic [7:0]        DB_IN,
    output logic [7:0]        DB_OUT,
    input  logic [CHW-1:0]    REQ_CH,
    input  logic              START,
    input  logic              EOP_IN_N,
    output logic [AW-1:0]     ADDR_OUT,
    output logic              AEN,
    output logic              ADSTB,
    output logic              TC,
    output logic              EOP_OUT_N,
    output logic              BUSY,
    input  logic [NUM_CH-1:0] AUTOINIT,
    input  logic [NUM_CH-1:0] DEC,
    output logic [NUM_CH-1:0] MASK,
    input  logic [NUM_CH-1:0] CLR_MASK,
    input  logic              CLR_FF
);

    typedef enum logic [2:0] {SI, S1, S2, S3, S4} state_t;

    localparam logic [1:0]     A_LAST  = 2'(AW / 8 - 1);
    localparam logic [1:0]     C_LAST  = 2'(CW / 8 - 1);
    localparam logic [3:0]     NCH     = 4'(NUM_CH);
    localparam logic [CHW:0]   NCH_REQ = (CHW + 1)'(NUM_CH);
    localparam logic [AW-1:0]  HI_MASK = ~AW'(255);

    state_t              state_q, state_d;
    logic [CHW-1:0]      ch_q;
    logic                first_q;
    logic                eop_q;
    logic [AW-1:0]       last_a_q;
    logic                rd_q;
    logic [1:0]          ptr_q, ptr_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;

    logic [AW-1:0]       base_addr_q [NUM_CH];
    logic [AW-1:0]       cur_addr_q  [NUM_CH];
    logic [CW-1:0]       base_cnt_q  [NUM_CH];
    logic [CW-1:0]       cur_cnt_q   [NUM_CH];

    logic [2:0]          reg_ch;
    logic                reg_sel;
    logic [CHW-1:0]      reg_idx;
    logic                ch_ok;
    logic                wr_go;
    logic                rd_now;
    logic                rd_rise;
    logic [1:0]          ptr_eff;
    logic [1:0]          ptr_last;
    logic [31:0]         rd_word;
    logic [AW-1:0]       cur_a;
    logic [CW-1:0]       cur_c;
    logic                term;
    logic                start_ok;

    assign reg_ch  = ADDR_L[3:1];
    assign reg_sel = ADDR_L[0];
    assign reg_idx = reg_ch[CHW-1:0];
    assign ch_ok   = {1'b0, reg_ch} < NCH;
    assign cur_a   = cur_addr_q[ch_q];
    assign cur_c   = cur_cnt_q[ch_q];

    // Byte pointer: CLR_FF acts first so a coincident access lands on byte 0.
    always_comb begin
        wr_go    = !CS_N && !IOW_N && (state_q == SI);
        rd_now   = !CS_N && !IOR_N;
        rd_rise  = rd_q && !rd_now;
        ptr_eff  = CLR_FF ? 2'd0 : ptr_q;
        ptr_last = reg_sel ? C_LAST : A_LAST;
        ptr_d    = ptr_eff;
        if (wr_go || rd_rise) begin
            ptr_d = (ptr_eff >= ptr_last) ? 2'd0 : ptr_eff + 2'd1;
        end
        rd_word = reg_sel ? 32'(cur_cnt_q[reg_idx]) : 32'(cur_addr_q[reg_idx]);
        DB_OUT  = (rd_now && ch_ok) ? rd_word[8*ptr_eff +: 8] : 8'h00;
    end

    always_comb begin
        state_d   = state_q;
        AEN       = 1'b0;
        ADSTB     = 1'b0;
        TC        = 1'b0;
        BUSY      = (state_q != SI);
        ADDR_OUT  = '0;
        start_ok  = START && ({1'b0, REQ_CH} < NCH_REQ) && !mask_q[REQ_CH];
        term      = 1'b0;
        mask_d    = mask_q & ~CLR_MASK;
        case (state_q)
            SI: if (start_ok) state_d = S1;
            S1: begin
                AEN      = 1'b1;
                ADDR_OUT = cur_a;
                ADSTB    = first_q || (((cur_a ^ last_a_q) & HI_MASK) != '0);
                state_d  = S2;
            end
            S2: begin
                AEN      = 1'b1;
                ADDR_OUT = cur_a;
                state_d  = S3;
            end
            S3: begin
                AEN      = 1'b1;
                ADDR_OUT = cur_a;
                state_d  = S4;
            end
            S4: begin
                TC   = (cur_c == '0);
                term = TC || eop_q;
                if (term && !AUTOINIT[ch_q]) mask_d[ch_q] = 1'b1;
                state_d = term ? SI : S1;
            end
            default: state_d = SI;
        endcase
        EOP_OUT_N = !TC;
        MASK      = mask_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= SI;
            ch_q     <= '0;
            first_q  <= 1'b0;
            eop_q    <= 1'b0;
            last_a_q <= '0;
            rd_q     <= 1'b0;
            ptr_q    <= 2'd0;
            mask_q   <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                base_addr_q[i] <= '0;
                cur_addr_q[i]  <= '0;
                base_cnt_q[i]  <= '0;
                cur_cnt_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            rd_q    <= rd_now;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;

            if (wr_go && ch_ok) begin
                if (reg_sel) begin
                    for (int b = 0; b < CW / 8; b++) begin
                        if (ptr_eff == 2'(b)) begin
                            base_cnt_q[reg_idx][8*b +: 8] <= DB_IN;
                            cur_cnt_q[reg_idx][8*b +: 8]  <= DB_IN;
                        end
                    end
                end else begin
                    for (int b = 0; b < AW / 8; b++) begin
                        if (ptr_eff == 2'(b)) begin
                            base_addr_q[reg_idx][8*b +: 8] <= DB_IN;
                            cur_addr_q[reg_idx][8*b +: 8]  <= DB_IN;
                        end
                    end
                end
            end

            if (state_q == SI && start_ok) begin
                ch_q    <= REQ_CH;
                first_q <= 1'b1;
                eop_q   <= 1'b0;
            end
            if (state_q == S1 && ADSTB) begin
                last_a_q <= cur_a;
                first_q  <= 1'b0;
            end
            if ((state_q == S1 || state_q == S2 || state_q == S3) && !EOP_IN_N) begin
                eop_q <= 1'b1;
            end

            // Autoinit reload takes precedence over the normal step.
            if (state_q == S4) begin
                if (term && AUTOINIT[ch_q]) begin
                    cur_addr_q[ch_q] <= base_addr_q[ch_q];
                    cur_cnt_q[ch_q]  <= base_cnt_q[ch_q];
                end else begin
                    cur_addr_q[ch_q] <= DEC[ch_q] ? cur_a - AW'(1) : cur_a + AW'(1);
                    cur_cnt_q[ch_q]  <= cur_c - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_chan_datapath.sv
// tb/tb_dma_chan_datapath.sv - directed self-checking bench for dma_chan_datapath
module tb_dma_chan_datapath;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CS_N, IOW_N, IOR_N;
    logic [3:0]  ADDR_L;
    logic [7:0]  DB_IN, DB_OUT;
    logic [1:0]  REQ_CH;
    logic        START, EOP_IN_N;
    logic [15:0] ADDR_OUT;
    logic        AEN, ADSTB, TC, EOP_OUT_N, BUSY;
    logic [3:0]  AUTOINIT, DEC, MASK, CLR_MASK;
    logic        CLR_FF;

    dma_chan_datapath #(.NUM_CH(4), .AW(16), .CW(16)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOW_N(IOW_N), .IOR_N(IOR_N),
        .ADDR_L(ADDR_L), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .REQ_CH(REQ_CH),
        .START(START), .EOP_IN_N(EOP_IN_N), .ADDR_OUT(ADDR_OUT), .AEN(AEN),
        .ADSTB(ADSTB), .TC(TC), .EOP_OUT_N(EOP_OUT_N), .BUSY(BUSY),
        .AUTOINIT(AUTOINIT), .DEC(DEC), .MASK(MASK), .CLR_MASK(CLR_MASK),
        .CLR_FF(CLR_FF)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    logic [15:0] s_addr [8];
    logic        s_stb  [8];
    int          n_xfer, n_tc, tc_at, bad_eop;
    logic [15:0] rd_val;
    logic [7:0]  rd_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_ff();
        @(negedge CLK); CLR_FF = 1'b1;
        @(negedge CLK); CLR_FF = 1'b0;
    endtask

    task automatic wr8(input logic [3:0] a, input logic [7:0] d, input logic cf);
        @(negedge CLK); ADDR_L = a; DB_IN = d; CS_N = 1'b0; IOW_N = 1'b0; CLR_FF = cf;
        @(negedge CLK); CS_N = 1'b1; IOW_N = 1'b1; CLR_FF = 1'b0;
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] d);
        clr_ff();
        wr8(a, d[7:0], 1'b0);
        wr8(a, d[15:8], 1'b0);
    endtask

    task automatic rd8(input logic [3:0] a, output logic [7:0] d);
        @(negedge CLK); ADDR_L = a; CS_N = 1'b0; IOR_N = 1'b0;
        #1 d = DB_OUT;
        @(negedge CLK); CS_N = 1'b1; IOR_N = 1'b1;
    endtask

    task automatic rd16(input logic [3:0] a, output logic [15:0] d);
        logic [7:0] lo, hi;
        clr_ff();
        rd8(a, lo);
        rd8(a, hi);
        d = {hi, lo};
    endtask

    task automatic clr_mask(input int ch);
        @(negedge CLK); CLR_MASK = 4'(1 << ch);
        @(negedge CLK); CLR_MASK = 4'h0;
    endtask

    // Starts a service and records every S1 (rising AEN) plus TC timing.
    task automatic serve(input int ch, input bit eop_s2, input bit rst_s3);
        bit prev_aen, seen_busy, done;
        int since_s1;
        n_xfer = 0; n_tc = 0; tc_at = -1; bad_eop = 0;
        prev_aen = 0; seen_busy = 0; done = 0; since_s1 = 0;
        @(negedge CLK); REQ_CH = 2'(ch); START = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge CLK); START = 1'b0; EOP_IN_N = 1'b1;
            #1;
            if (AEN && !prev_aen) begin
                if (n_xfer < 8) begin
                    s_addr[n_xfer] = ADDR_OUT;
                    s_stb[n_xfer]  = ADSTB;
                end
                n_xfer++;
                since_s1 = 0;
            end else begin
                since_s1++;
            end
            if (TC) begin
                n_tc++;
                tc_at = n_xfer;
            end
            if (EOP_OUT_N !== !TC) bad_eop++;
            if (eop_s2 && n_xfer == 1 && since_s1 == 1) EOP_IN_N = 1'b0;
            if (rst_s3 && n_xfer == 1 && since_s1 == 2) begin
                RESET = 1'b1;
                @(negedge CLK); RESET = 1'b0;
                #1;
                if (TC) n_tc++;
                done = 1;
                break;
            end
            prev_aen = AEN;
            if (BUSY) seen_busy = 1;
            else if (seen_busy) begin
                done = 1;
                break;
            end
        end
        check($sformatf("serve_ch%0d_completes", ch), 32'(done), 32'd1);
    endtask

    initial begin
        RESET = 1'b1; CS_N = 1'b1; IOW_N = 1'b1; IOR_N = 1'b1; ADDR_L = 4'h0;
        DB_IN = 8'h00; REQ_CH = 2'd0; START = 1'b0; EOP_IN_N = 1'b1;
        AUTOINIT = 4'h0; DEC = 4'h0; CLR_MASK = 4'h0; CLR_FF = 1'b0;

        vecs[0] = '{4'h0, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{4'h1, 16'h0102, 16'h0102};
        vecs[2] = '{4'h2, 16'hA55A, 16'hA55A};
        vecs[3] = '{4'h5, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{4'h6, 16'h0000, 16'h0000};
        vecs[5] = '{4'h7, 16'h8001, 16'h8001};
        vecs[6] = '{4'h8, 16'h1234, 16'h0000};
        vecs[7] = '{4'hF, 16'hCAFE, 16'h0000};

        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_aen", 32'(AEN), 32'd0);
        check("rst_adstb", 32'(ADSTB), 32'd0);
        check("rst_tc", 32'(TC), 32'd0);
        check("rst_eop_out_n", 32'(EOP_OUT_N), 32'd1);
        check("rst_db_out", 32'(DB_OUT), 32'd0);
        check("rst_addr_out", 32'(ADDR_OUT), 32'd0);
        check("rst_mask", 32'(MASK), 32'hF);
        rd16(4'h3, rd_val);
        check("rst_ch1_count", 32'(rd_val), 32'd0);

        for (int i = 0; i < 8; i++) wr16(vecs[i].addr, vecs[i].wdata);
        for (int i = 0; i < 8; i++) begin
            rd16(vecs[i].addr, rd_val);
            check($sformatf("vec%0d_reg%0h", i, vecs[i].addr), 32'(rd_val), 32'(vecs[i].exp));
        end
        #1 check("db_out_idle", 32'(DB_OUT), 32'd0);

        clr_ff();
        wr8(4'h2, 8'hAB, 1'b0);
        clr_ff();
        rd8(4'h2, rd_b);
        check("clrff_read_low", 32'(rd_b), 32'hAB);

        clr_ff();
        wr8(4'h0, 8'h11, 1'b0);
        wr8(4'h0, 8'h22, 1'b1);
        wr8(4'h0, 8'h33, 1'b0);
        rd16(4'h0, rd_val);
        check("clrff_coincident_write", 32'(rd_val), 32'h3322);

        wr16(4'h2, 16'h1234);
        wr16(4'h3, 16'h0002);
        clr_mask(1);
        check("ch1_mask_cleared", 32'(MASK[1]), 32'd0);
        serve(1, 1'b0, 1'b0);
        check("r22_xfers", 32'(n_xfer), 32'd3);
        check("r22_addr0", 32'(s_addr[0]), 32'h1234);
        check("r22_addr1", 32'(s_addr[1]), 32'h1235);
        check("r22_addr2", 32'(s_addr[2]), 32'h1236);
        check("r22_stb", 32'({s_stb[0], s_stb[1], s_stb[2]}), 32'b100);
        check("r22_tc_count", 32'(n_tc), 32'd1);
        check("r22_tc_at", 32'(tc_at), 32'd3);
        check("r22_eop_out", 32'(bad_eop), 32'd0);
        check("r22_mask1", 32'(MASK[1]), 32'd1);
        rd16(4'h2, rd_val);
        check("r22_cur_addr", 32'(rd_val), 32'h1237);
        rd16(4'h3, rd_val);
        check("r22_cur_count", 32'(rd_val), 32'hFFFF);

        @(negedge CLK); REQ_CH = 2'd1; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        #1 check("masked_start_ignored", 32'(BUSY), 32'd0);

        wr16(4'h0, 16'h12FF);
        wr16(4'h1, 16'h0001);
        clr_mask(0);
        serve(0, 1'b0, 1'b0);
        check("r23_xfers", 32'(n_xfer), 32'd2);
        check("r23_addr", 32'({s_addr[0], s_addr[1]}), 32'h12FF1300);
        check("r23_stb", 32'({s_stb[0], s_stb[1]}), 32'b11);
        check("r23_tc_at", 32'(tc_at), 32'd2);

        DEC = 4'b0001;
        wr16(4'h0, 16'h1300);
        wr16(4'h1, 16'h0001);
        clr_mask(0);
        serve(0, 1'b0, 1'b0);
        DEC = 4'b0000;
        check("dec_addr", 32'({s_addr[0], s_addr[1]}), 32'h130012FF);
        check("dec_stb", 32'({s_stb[0], s_stb[1]}), 32'b11);

        AUTOINIT = 4'b0100;
        wr16(4'h4, 16'h4000);
        wr16(4'h5, 16'h0000);
        clr_mask(2);
        serve(2, 1'b0, 1'b0);
        check("r24_xfers", 32'(n_xfer), 32'd1);
        check("r24_tc_at", 32'(tc_at), 32'd1);
        check("r24_mask2", 32'(MASK[2]), 32'd0);
        rd16(4'h4, rd_val);
        check("r24_addr_reload", 32'(rd_val), 32'h4000);
        rd16(4'h5, rd_val);
        check("r24_count_reload", 32'(rd_val), 32'h0000);
        AUTOINIT = 4'b0000;

        wr16(4'h6, 16'h2000);
        wr16(4'h7, 16'h0005);
        clr_mask(3);
        serve(3, 1'b1, 1'b0);
        check("r25_xfers", 32'(n_xfer), 32'd1);
        check("r25_no_tc", 32'(n_tc), 32'd0);
        check("r25_mask3", 32'(MASK[3]), 32'd1);
        rd16(4'h7, rd_val);
        check("r25_count", 32'(rd_val), 32'h0004);
        rd16(4'h6, rd_val);
        check("r25_addr", 32'(rd_val), 32'h2001);

        wr16(4'h2, 16'h5678);
        wr16(4'h3, 16'h0003);
        clr_mask(1);
        serve(1, 1'b0, 1'b1);
        check("r26_rst_busy", 32'(BUSY), 32'd0);
        check("r26_rst_aen", 32'(AEN), 32'd0);
        check("r26_rst_no_tc", 32'(n_tc), 32'd0);
        check("r26_rst_mask", 32'(MASK), 32'hF);
        rd16(4'h2, rd_val);
        check("r26_rst_addr", 32'(rd_val), 32'h0000);
        rd16(4'h3, rd_val);
        check("r26_rst_count", 32'(rd_val), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_chan_datapath.md
DMA_CHAN_DATAPATH -- requirements
Module: dma_chan_datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RESET.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- NUM_CH, 4, channel count (1..8).
- AW, 16, address width in bits (multiple of 8, ≤32).
- CW, 16, count width in bits (multiple of 8, ≤32).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RESET, in, 1, sync reset.
- CS_N, in, 1, CPU chip select.
- IOW_N, in, 1, CPU register write strobe; sampled when CS_N=0.
- IOR_N, in, 1, CPU register read strobe; sampled when CS_N=0.
- ADDR_L, in, 4, register select {ch[2:0], sel}: sel 0 = address, 1 = count.
- DB_IN, in, 8, CPU write data.
- DB_OUT, out, 8, CPU read data.
- REQ_CH, in, $clog2(NUM_CH) (min 1), channel granted by priority logic.
- START, in, 1, begin service of REQ_CH (1-cycle pulse).
- EOP_IN_N, in, 1, external end-of-process, active low.
- ADDR_OUT, out, AW, transfer address.
- AEN, out, 1, address enable.
- ADSTB, out, 1, upper-address strobe.
- TC, out, 1, terminal count pulse.
- EOP_OUT_N, out, 1, EOP drive, active low.
- BUSY, out, 1, transfer in progress.
- AUTOINIT, in, NUM_CH, per-channel autoinitialize enable.
- DEC, in, NUM_CH, per-channel address decrement.
- MASK, out, NUM_CH, per-channel mask; set at terminal count when that channel's AUTOINIT=0.
- CLR_MASK, in, NUM_CH, per-channel mask clear.
- CLR_FF, in, 1, clear byte pointer.

Function
REQ-004 Each channel SHALL hold base/current address (AW) and base/current word count (CW).
REQ-005 A CPU write (CS_N=0, IOW_N=0, BUSY=0) SHALL load byte ptr of both base and current register selected by ADDR_L, then advance ptr; ptr wraps at W/8-1 to 0.
REQ-006 A CPU read SHALL present byte ptr of the current register on DB_OUT the same cycle (combinational), advancing ptr on the strobe's rising edge; DB_OUT=0 when not reading.
REQ-007 Channel index ≥NUM_CH SHALL ignore writes and read 0x00; ptr still advances.
REQ-008 CLR_FF SHALL zero the byte pointer; if coincident with a write, the write uses byte 0 and ptr becomes 1.
REQ-009 FSM states SI, S1, S2, S3, S4; SI exits only on START while MASK[REQ_CH]=0, latching REQ_CH as active channel.
REQ-010 S1: AEN=1, ADDR_OUT=current address; ADSTB=1 only if first transfer of the service or address bits [AW-1:8] changed since last strobe.
REQ-011 S2: ADSTB=0, AEN=1; S3: AEN=1, data phase, one cycle.
REQ-012 S4: address ±1 (DEC) mod 2^AW; count-1 mod 2^CW; TC=1 for one cycle if count was 0 before decrement.
REQ-013 After S4: TC or latched EOP -> SI; else -> S1 (demand service continues).
REQ-014 On TC or EOP with AUTOINIT=1, current registers SHALL reload from base in S4; else MASK bit set.
REQ-015 EOP_IN_N=0 sampled in S1-S3 SHALL be latched; transfer completes S4 and terminates without TC.
REQ-016 EOP_OUT_N=0 SHALL coincide with TC; otherwise 1.
REQ-017 BUSY=1 in S1-S4; CPU writes while BUSY SHALL be ignored.
REQ-018 START while BUSY SHALL be ignored.
REQ-019 CLR_MASK SHALL clear mask bits; set by S4 TC in same cycle wins.

Reset
REQ-020 RESET SHALL force SI, all registers 0, ptr 0, MASK all 1, AEN/ADSTB/TC/BUSY=0, EOP_OUT_N=1, DB_OUT=0, ADDR_OUT=0.
REQ-021 RESET mid-transfer SHALL abort next edge without TC or register update.

Verification
REQ-022 Write ch1 addr bytes 0x34,0x12, count 0x02,0x00, CLR_MASK[1], START -> 3 transfers at 0x1234-0x1236, TC in third S4, MASK[1]=1.
REQ-023 ch0 addr 0x12FF, count 1, DEC=0 -> ADSTB both transfers (0x12FF, 0x1300).
REQ-024 ch2 AUTOINIT=1, count 0 -> single transfer, TC, current reloads to base, MASK[2]=0.
REQ-025 EOP_IN_N=0 in S2 of first transfer, count 5 -> one transfer, no TC, count reads 4.
REQ-026 Write 0xAB, CLR_FF, read -> DB_OUT=low byte 0xAB; reset mid-S3 -> SI, registers 0.
